// File: rtl/dmem_ctrl.sv
// dmem_ctrl
//   Data-memory controller behind the MEM stage. Accepts one read or write
//   request while idle, waits WAIT_CYCLES wait states, then performs the
//   access against an internal word-addressed RAM and pulses `done`.
//   A simultaneous read+write request is rejected with a one-cycle `err`.
//
// Optional build macro:
//   DMEM_BYTE_WE_EN - adds the `req_be` port; writes update only enabled lanes.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   req_re     in   read request (sampled only while idle)
//   req_we     in   write request (sampled only while idle)
//   req_addr   in   word address
//   req_wdata  in   store data
//   req_be     in   byte-lane write enables (DMEM_BYTE_WE_EN only)
//   rdata      out  last read result, held until the next read completes
//   done       out  one-cycle completion pulse
//   busy       out  transaction in flight (state != IDLE)
//   err        out  one-cycle pulse for a rejected request
module dmem_ctrl #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_WE_EN
  input  logic [3:0]        req_be,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              op_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
`ifdef DMEM_BYTE_WE_EN
  logic [3:0]        lat_be;
`endif

  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign busy = (state != S_IDLE);

  // Transaction FSM: latch the request in IDLE, count wait states, then
  // perform the access. done/err default low so they are single-cycle pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      op_write  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
`ifdef DMEM_BYTE_WE_EN
      lat_be    <= 4'd0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_re ^ req_we) begin
            op_write  <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
`ifdef DMEM_BYTE_WE_EN
            lat_be    <= req_be;
`endif
            if (WAIT_CYCLES == 0) begin
              state <= S_ACCESS;
            end else begin
              cnt   <= 4'(WAIT_CYCLES);
              state <= S_WAIT;
            end
          end else if (req_re && req_we) begin
            // Ambiguous request: reject without touching memory.
            err <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!op_write) begin
            rdata <= mem[lat_addr];
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM write port. The RAM itself is never reset; a reset during a
  // transaction forces state to IDLE, so the pending write never lands.
  always_ff @(posedge clock) begin
    if (state == S_ACCESS && op_write) begin
`ifdef DMEM_BYTE_WE_EN
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) begin
          mem[lat_addr][8*i +: 8] <= lat_wdata[8*i +: 8];
        end
      end
`else
      mem[lat_addr] <= lat_wdata;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl
//   Self-checking bench for dmem_ctrl. Three instances cover WAIT_CYCLES of
//   1 (table vectors, random traffic, reset checks), 0 (back-to-back reads)
//   and 3 (reset during wait states). Expected read data comes from a
//   word-level memory model held in an associative array.
module tb_dmem_ctrl;

  localparam int AW = 11;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  // Instance with WAIT_CYCLES = 1
  logic          re1, we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1, rdata1;
  logic          done1, busy1, err1;
  // Instance with WAIT_CYCLES = 0
  logic          re0, we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0, rdata0;
  logic          done0, busy0, err0;
  // Instance with WAIT_CYCLES = 3
  logic          re3, we3;
  logic [AW-1:0] addr3;
  logic [DW-1:0] wdata3, rdata3;
  logic          done3, busy3, err3;
`ifdef DMEM_BYTE_WE_EN
  logic [3:0]    be1, be0, be3;
`endif

  dmem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u1 (
    .clock(clock), .reset(reset), .req_re(re1), .req_we(we1),
    .req_addr(addr1), .req_wdata(wdata1),
`ifdef DMEM_BYTE_WE_EN
    .req_be(be1),
`endif
    .rdata(rdata1), .done(done1), .busy(busy1), .err(err1));

  dmem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) u0 (
    .clock(clock), .reset(reset), .req_re(re0), .req_we(we0),
    .req_addr(addr0), .req_wdata(wdata0),
`ifdef DMEM_BYTE_WE_EN
    .req_be(be0),
`endif
    .rdata(rdata0), .done(done0), .busy(busy0), .err(err0));

  dmem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3)) u3 (
    .clock(clock), .reset(reset), .req_re(re3), .req_we(we3),
    .req_addr(addr3), .req_wdata(wdata3),
`ifdef DMEM_BYTE_WE_EN
    .req_be(be3),
`endif
    .rdata(rdata3), .done(done3), .busy(busy3), .err(err3));

  int total = 0;
  int bad   = 0;

  // Word-level memory model for the WAIT_CYCLES = 1 instance.
  logic [DW-1:0] model_mem [int];

  typedef struct {
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // A write keeps old bytes on lanes whose enable is clear (byte-enable build).
  function automatic logic [DW-1:0] mergeWrite(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [3:0] be);
`ifdef DMEM_BYTE_WE_EN
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
`else
    logic [3:0] unused_be;
    unused_be = be;
    return (old_w & '0) | new_w;
`endif
  endfunction

  // Present one request to u1 for exactly one rising edge; returns at the
  // falling edge just after the acceptance edge.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [3:0] be);
    @(negedge clock);
    re1 = rd; we1 = wr; addr1 = a; wdata1 = d;
`ifdef DMEM_BYTE_WE_EN
    be1 = be;
`else
    if (be === 4'hx) $display("[TB] be unknown");
`endif
    @(negedge clock);
    re1 = 1'b0; we1 = 1'b0;
  endtask

  // Full transaction on u1 with timing, pulse and data checks.
  task automatic runTxn(input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] be,
                        input logic [DW-1:0] exp_rdata, input string tag);
    int busy_n;
    bit done_seen;
    logic [DW-1:0] old_w;
    applyStimulus(rd, wr, a, d, be);
    if (rd && wr) begin
      checkOutput({tag, "_err"}, 32'(err1), 32'd1);
      checkOutput({tag, "_err_busy"}, 32'(busy1), 32'd0);
      done_seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clock);
        if (done1) done_seen = 1'b1;
        if (c == 0) checkOutput({tag, "_err_pulse"}, 32'(err1), 32'd0);
      end
      checkOutput({tag, "_err_nodone"}, 32'(done_seen), 32'd0);
    end else if (rd || wr) begin
      busy_n = 0;
      for (int c = 0; c < 20; c++) begin
        if (done1) break;
        if (busy1) busy_n++;
        @(negedge clock);
      end
      checkOutput({tag, "_done"}, 32'(done1), 32'd1);
      checkOutput({tag, "_busy_cycles"}, busy_n, 32'd2);
      checkOutput({tag, "_busy_at_done"}, 32'(busy1), 32'd0);
      checkOutput({tag, "_err_at_done"}, 32'(err1), 32'd0);
      if (rd) begin
        checkOutput({tag, "_rdata"}, rdata1, exp_rdata);
      end else begin
        old_w = model_mem.exists(int'(a)) ? model_mem[int'(a)] : '0;
        model_mem[int'(a)] = mergeWrite(old_w, d, be);
      end
      @(negedge clock);
      checkOutput({tag, "_done_pulse"}, 32'(done1), 32'd0);
    end
  endtask

  initial begin
    int pool [8];
    int busy_n;
    bit flag;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0] be;
    int k;

    reset = 1'b1;
    re1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    re0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    re3 = 0; we3 = 0; addr3 = '0; wdata3 = '0;
`ifdef DMEM_BYTE_WE_EN
    be1 = 4'hF; be0 = 4'hF; be3 = 4'hF;
`endif
    #12;
    checkOutput("reset_rdata", rdata1, 32'd0);
    checkOutput("reset_busy", 32'(busy1), 32'd0);
    checkOutput("reset_done", 32'(done1), 32'd0);
    checkOutput("reset_err", 32'(err1), 32'd0);
    reset = 1'b0;

    // Directed vectors: rd, wr, addr, wdata, be, expected rdata
    vecs[0]  = '{1'b0, 1'b1, 11'h005, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 11'h005, 32'h0,        4'hF, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 11'h7FF, 32'h5A5AA5A5, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 11'h7FF, 32'h0,        4'hF, 32'h5A5AA5A5};
    vecs[4]  = '{1'b0, 1'b1, 11'h010, 32'hCAFEF00D, 4'hF, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 11'h010, 32'h00000000, 4'hF, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 11'h010, 32'h0,        4'hF, 32'hCAFEF00D};
    vecs[7]  = '{1'b0, 1'b1, 11'h003, 32'h11223344, 4'hF, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 11'h003, 32'hAABBCCDD, 4'h5, 32'h0};
`ifdef DMEM_BYTE_WE_EN
    vecs[9]  = '{1'b1, 1'b0, 11'h003, 32'h0,        4'hF, 32'h11BB33DD};
    vecs[10] = '{1'b0, 1'b1, 11'h003, 32'hFFFFFFFF, 4'h0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 11'h003, 32'h0,        4'hF, 32'h11BB33DD};
`else
    vecs[9]  = '{1'b1, 1'b0, 11'h003, 32'h0,        4'hF, 32'hAABBCCDD};
    vecs[10] = '{1'b0, 1'b1, 11'h003, 32'hFFFFFFFF, 4'h0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 11'h003, 32'h0,        4'hF, 32'hFFFFFFFF};
`endif
    for (int i = 0; i < 12; i++) begin
      runTxn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             vecs[i].exp_rdata, $sformatf("vec%0d", i));
    end

    // A write held high while a read is in flight must be ignored.
    applyStimulus(1'b1, 1'b0, 11'h005, 32'h0, 4'hF);
    we1 = 1'b1; addr1 = 11'h005; wdata1 = 32'h0;
    flag = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (done1) break;
      if (err1) flag = 1'b1;
      @(negedge clock);
    end
    we1 = 1'b0;
    checkOutput("ignore_done", 32'(done1), 32'd1);
    checkOutput("ignore_rdata", rdata1, 32'hDEADBEEF);
    checkOutput("ignore_no_err", 32'(flag), 32'd0);
    @(negedge clock);
    checkOutput("ignore_not_accepted", 32'(busy1), 32'd0);
    runTxn(1'b1, 1'b0, 11'h005, 32'h0, 4'hF, model_mem[5], "ignore_readback");

    // Randomized traffic over a small address pool.
    for (int i = 0; i < 8; i++) begin
      pool[i] = int'($urandom_range(0, 2047));
      runTxn(1'b0, 1'b1, AW'(pool[i]), $urandom, 4'hF, 32'h0, $sformatf("rinit%0d", i));
    end
    for (int i = 0; i < 40; i++) begin
      a = AW'(pool[$urandom_range(0, 7)]);
      d = $urandom;
      be = 4'($urandom_range(0, 15));
      k = int'($urandom_range(0, 9));
      if (k < 4)      runTxn(1'b1, 1'b0, a, d, be, model_mem[int'(a)], $sformatf("rnd%0d_rd", i));
      else if (k < 9) runTxn(1'b0, 1'b1, a, d, be, 32'h0, $sformatf("rnd%0d_wr", i));
      else            runTxn(1'b1, 1'b1, a, d, be, 32'h0, $sformatf("rnd%0d_rw", i));
    end

    // Asynchronous reset mid-cycle while done/rdata are showing a read.
    applyStimulus(1'b1, 1'b0, 11'h7FF, 32'h0, 4'hF);
    for (int c = 0; c < 10; c++) begin
      if (done1) break;
      @(negedge clock);
    end
    checkOutput("areset_pre_rdata", rdata1, model_mem[32'h7FF]);
    #2 reset = 1'b1;
    #1;
    checkOutput("areset_rdata", rdata1, 32'd0);
    checkOutput("areset_done", 32'(done1), 32'd0);
    checkOutput("areset_busy", 32'(busy1), 32'd0);
    checkOutput("areset_err", 32'(err1), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // WAIT_CYCLES = 0: two writes, then back-to-back reads.
    @(negedge clock); we0 = 1'b1; addr0 = 11'h000; wdata0 = 32'hA0A0A0A0;
    @(negedge clock); we0 = 1'b0; checkOutput("w0_busy", 32'(busy0), 32'd1);
    @(negedge clock); checkOutput("w0_done", 32'(done0), 32'd1);
    we0 = 1'b1; addr0 = 11'h7FF; wdata0 = 32'hB1B1B1B1;
    @(negedge clock); we0 = 1'b0; checkOutput("w0b_busy", 32'(busy0), 32'd1);
    @(negedge clock); checkOutput("w0b_done", 32'(done0), 32'd1);
    re0 = 1'b1; addr0 = 11'h000;
    @(negedge clock); re0 = 1'b0;
    checkOutput("b2b_r1_busy", 32'(busy0), 32'd1);
    checkOutput("b2b_r1_nodone", 32'(done0), 32'd0);
    @(negedge clock);
    checkOutput("b2b_r1_done", 32'(done0), 32'd1);
    checkOutput("b2b_r1_rdata", rdata0, 32'hA0A0A0A0);
    re0 = 1'b1; addr0 = 11'h7FF;
    @(negedge clock); re0 = 1'b0;
    checkOutput("b2b_r2_busy", 32'(busy0), 32'd1);
    checkOutput("b2b_r2_nodone", 32'(done0), 32'd0);
    @(negedge clock);
    checkOutput("b2b_r2_done", 32'(done0), 32'd1);
    checkOutput("b2b_r2_rdata", rdata0, 32'hB1B1B1B1);

    // WAIT_CYCLES = 3: seed address 7, then reset during a pending write.
    @(negedge clock); we3 = 1'b1; addr3 = 11'h007; wdata3 = 32'h0BADF00D;
    @(negedge clock); we3 = 1'b0;
    busy_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (done3) break;
      if (busy3) busy_n++;
      @(negedge clock);
    end
    checkOutput("w3_done", 32'(done3), 32'd1);
    checkOutput("w3_busy_cycles", busy_n, 32'd4);
    @(negedge clock); we3 = 1'b1; addr3 = 11'h007; wdata3 = 32'h12345678;
    @(negedge clock); we3 = 1'b0; checkOutput("w3abort_busy", 32'(busy3), 32'd1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 checkOutput("w3abort_busy_reset", 32'(busy3), 32'd0);
    @(negedge clock); reset = 1'b0;
    flag = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (done3) flag = 1'b1;
    end
    checkOutput("w3abort_nodone", 32'(flag), 32'd0);
    re3 = 1'b1; addr3 = 11'h007;
    @(negedge clock); re3 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done3) break;
      @(negedge clock);
    end
    checkOutput("w3abort_rd_done", 32'(done3), 32'd1);
    checkOutput("w3abort_rdata", rdata3, 32'h0BADF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller sitting directly downstream of the pipeline control unit's MEM stage. It accepts a single read or write request per transaction, performs it against an internal word-addressed RAM after a configurable number of wait states, returns read data with a one-cycle `done` pulse, and drives `busy` so the pipeline holds MEM/WB while an access is in flight.

## Interface
- `ADDR_W`, 11: word-address width; RAM depth is 2^ADDR_W words.
- `DATA_W`, 32: word width.
- `WAIT_CYCLES`, 1: wait states inserted before the access edge; legal range 0–15.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `req_re` in 1: read request from the MEM stage.
- `req_we` in 1: write request from the MEM stage.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: store data.
- `req_be` in 4: byte-lane write enables, bit i covers bits [8i+7:8i]; present only with `DMEM_BYTE_WE_EN`.
- `rdata` out DATA_W: read result; holds its value until the next read completes.
- `done` out 1: one-cycle completion pulse for the accepted read or write.
- `busy` out 1: transaction in flight; the pipeline must not present a new request while high.
- `err` out 1: one-cycle pulse flagging a rejected request.

## Operation
- FSM states:
  - IDLE: no transaction; `busy` = 0.
  - WAIT: counting down wait states.
  - ACCESS: memory operation performed on the next edge.
- IDLE, `req_re` xor `req_we` at a rising edge:
  - latch op, `req_addr`, `req_wdata` (and `req_be`).
  - go to WAIT with counter = WAIT_CYCLES, or straight to ACCESS if WAIT_CYCLES = 0.
- IDLE, `req_re` and `req_we` both high: no latch, no memory access, `err` = 1 for the next cycle, stay IDLE.
- WAIT: decrement the counter each edge; go to ACCESS on the edge where the counter goes 1→0.
- ACCESS edge:
  - Read: `rdata` <= mem[addr].
  - Write: mem[addr] <= latched data.
  - In both cases `done` <= 1 and the FSM returns to IDLE.
- Requests are sampled only in IDLE. A request asserted while `busy` = 1 is ignored: no `err` and no queueing.
- `busy` is decoded combinationally from state (state ≠ IDLE).
- No forwarding is needed: a read accepted after a write's `done` returns the new data.
- Counter width is 4 bits.

## Timing
- Reset values: state IDLE, counter 0, `rdata` 0, `done` 0, `err` 0, `busy` 0. RAM contents are not reset.
- With the request accepted at edge E0, the access happens at edge E(WAIT_CYCLES+1), and `done` (and new `rdata` for reads) is high for the one cycle after it.
- Latency is WAIT_CYCLES+1 cycles. `busy` is high from just after E0 to just after E(WAIT_CYCLES+1).
- Back-to-back: a request present during the `done` cycle is accepted at the following edge. Maximum rate is one transaction per WAIT_CYCLES+2 cycles.
- Reset asserted mid-transaction:
  - aborts immediately; a pending write is discarded (RAM unchanged).
  - `done` never fires for it; outputs take reset values.
- `done` and `err` never assert in the same cycle.
- Address width is exact, so out-of-range addresses cannot occur. Upper address bits from the pipeline are dropped by the caller.

## Configuration
- `DMEM_BYTE_WE_EN` defined:
  - the `req_be` port exists.
  - writes update only the lanes whose `req_be` bit is set.
  - `req_be` = 4'b0000 writes nothing but still completes normally with `done`.
  - reads ignore `req_be`.
- `DMEM_BYTE_WE_EN` undefined:
  - no `req_be` port.
  - every write updates the full word.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> `rdata` = 0, `done` = 0, `err` = 0, `busy` = 0 immediately.
- WAIT_CYCLES = 1: write 0xDEADBEEF to address 0x005, then read 0x005:
  - `busy` high for 2 cycles per transaction.
  - `done` one cycle after each access edge.
  - `rdata` = 0xDEADBEEF.
- WAIT_CYCLES = 0: back-to-back reads of addresses 0x000 and 0x7FF, the second presented during the first's `done` cycle -> both accepted, each completing with 1-cycle latency.
- `req_re` = `req_we` = 1 with address 0x010 -> `err` pulses once, `busy` stays 0, mem[0x010] unchanged, `done` never asserts.
- With `DMEM_BYTE_WE_EN`: mem[3] = 0x11223344, then write 0xAABBCCDD with `req_be` = 4'b0101 -> read back 0x11BB33DD. With `req_be` = 0 -> word unchanged and `done` still pulses.
- Write 0x12345678 to address 7 with WAIT_CYCLES = 3, then assert `reset` during WAIT -> no `done`; a subsequent read of address 7 returns the prior contents.
